// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler in front of the two-lane encoder.
// Arbitrates between the ordered-set source and the transport byte stream.
// Frames the chosen bytes into whole encoder symbols: 1 byte at Gen4, 16 at Gen3, 8 at Gen2.
// d_sel stays constant for a whole symbol, and symbols follow each other with no gap cycles.
module tx_symbol_scheduler #(
  parameter int MAX_OS_RUN = 4
) (
  input  logic       enc_clk,
  input  logic       rst,
  input  logic [1:0] gen_speed,
  input  logic       os_req,
  input  logic [3:0] os_type,
  input  logic [7:0] os_lane0,
  input  logic [7:0] os_lane1,
  output logic       os_ack,
  input  logic       tl_valid,
  input  logic [7:0] tl_lane0,
  input  logic [7:0] tl_lane1,
  output logic       tl_ready,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic [3:0] d_sel,
  output logic       enable,
  output logic       sym_start,
  output logic       underrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OS_SYM = 2'd1,
    TL_SYM = 2'd2,
    FLUSH  = 2'd3
  } schedState_e;

  localparam logic [3:0] D_SEL_TL   = 4'd8;
  localparam logic [3:0] D_SEL_IDLE = 4'd9;

  schedState_e r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_run;
  logic [3:0]  r_osType;
  logic [1:0]  r_genPrev;

  schedState_e w_nextState;
  logic [3:0]  w_nextCnt;
  logic [3:0]  w_nextRun;
  logic [3:0]  w_nextOsType;
  logic [3:0]  w_lastIdx;
  logic        w_isLast;
  logic        w_flush;
  logic        w_grantOs;
  logic        w_arb;
  logic [7:0]  w_lane0;
  logic [7:0]  w_lane1;
  logic [3:0]  w_dSel;
  logic        w_enable;
  logic        w_symStart;
  logic        w_underrun;

  // Index of the last byte of a symbol at the current link speed; invalid speed never frames symbols.
  always_comb begin
    w_lastIdx = 4'd7;
    case (gen_speed)
      2'd0:    w_lastIdx = 4'd0;
      2'd1:    w_lastIdx = 4'd15;
      default: w_lastIdx = 4'd7;
    endcase
  end

  assign w_isLast  = (r_cnt >= w_lastIdx);
  assign w_flush   = (gen_speed != r_genPrev) || (gen_speed == 2'd3);
  assign w_grantOs = os_req && !(tl_valid && (r_run == 4'(MAX_OS_RUN)));

  // Next-state, handshake and next output values; a speed change or an invalid speed always wins and aborts the symbol.
  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_nextRun    = r_run;
    w_nextOsType = r_osType;
    w_arb        = 1'b0;
    w_lane0      = 8'h00;
    w_lane1      = 8'h00;
    w_dSel       = D_SEL_IDLE;
    w_enable     = 1'b1;
    w_symStart   = 1'b0;
    w_underrun   = 1'b0;
    os_ack       = 1'b0;
    tl_ready     = 1'b0;
    if (rst) begin
      w_enable = 1'b0;
    end else if (w_flush) begin
      w_nextState = FLUSH;
      w_nextCnt   = 4'd0;
      w_enable    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_arb = 1'b1;
        end
        OS_SYM: begin
          os_ack     = 1'b1;
          w_dSel     = r_osType;
          w_symStart = (r_cnt == 4'd0);
          if (os_req) begin
            w_lane0 = os_lane0;
            w_lane1 = os_lane1;
          end else begin
            w_underrun = 1'b1;
          end
          if (w_isLast) w_arb = 1'b1;
          else          w_nextCnt = r_cnt + 4'd1;
        end
        TL_SYM: begin
          tl_ready   = 1'b1;
          w_dSel     = D_SEL_TL;
          w_symStart = (r_cnt == 4'd0);
          if (tl_valid) begin
            w_lane0 = tl_lane0;
            w_lane1 = tl_lane1;
          end else begin
            w_underrun = 1'b1;
          end
          if (w_isLast) w_arb = 1'b1;
          else          w_nextCnt = r_cnt + 4'd1;
        end
        FLUSH: begin
          w_nextState = IDLE;
          w_nextRun   = 4'd0;
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
      if (w_arb) begin
        w_nextCnt = 4'd0;
        if (w_grantOs) begin
          w_nextState  = OS_SYM;
          w_nextOsType = os_type;
          w_nextRun    = (r_run == 4'd15) ? r_run : r_run + 4'd1;
        end else if (tl_valid) begin
          w_nextState = TL_SYM;
          w_nextRun   = 4'd0;
        end else begin
          w_nextState = IDLE;
          w_nextRun   = 4'd0;
        end
      end
    end
  end

  // State, counters and the registered encoder-facing outputs; the previous speed is tracked even in reset so release is clean.
  always_ff @(posedge enc_clk) begin
    r_genPrev <= gen_speed;
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_run     <= 4'd0;
      r_osType  <= 4'd0;
      lane_0_tx <= 8'h00;
      lane_1_tx <= 8'h00;
      d_sel     <= D_SEL_IDLE;
      enable    <= 1'b0;
      sym_start <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_run     <= w_nextRun;
      r_osType  <= w_nextOsType;
      lane_0_tx <= w_lane0;
      lane_1_tx <= w_lane1;
      d_sel     <= w_dSel;
      enable    <= w_enable;
      sym_start <= w_symStart;
      underrun  <= w_underrun;
    end
  end

endmodule
